// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// Start/busy/done handshake; diff, borrow and overflow hold until the next completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [WIDTH-1:0] a_sh, a_sh_nxt;
    logic [WIDTH-1:0] b_sh, b_sh_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             br, br_nxt;
    logic             a_msb, a_msb_nxt;
    logic             b_msb, b_msb_nxt;
    logic             busy_nxt, done_nxt, borrow_nxt, overflow_nxt;
    logic [WIDTH-1:0] diff_nxt;

    // Full-subtractor cell for the bit at the LSB of the operand registers
    logic d_bit, br_bit;
    assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
    assign br_bit = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

    // Next-state and datapath; the minuend register doubles as the result register,
    // difference bits entering at the MSB as minuend bits leave at the LSB.
    always_comb begin
        state_nxt    = state;
        a_sh_nxt     = a_sh;
        b_sh_nxt     = b_sh;
        cnt_nxt      = cnt;
        br_nxt       = br;
        a_msb_nxt    = a_msb;
        b_msb_nxt    = b_msb;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        diff_nxt     = diff;
        borrow_nxt   = borrow;
        overflow_nxt = overflow;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    a_sh_nxt  = a;
                    b_sh_nxt  = b;
                    cnt_nxt   = '0;
                    br_nxt    = 1'b0;
                    a_msb_nxt = a[WIDTH-1];
                    b_msb_nxt = b[WIDTH-1];
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                a_sh_nxt = {d_bit, a_sh[WIDTH-1:1]};
                b_sh_nxt = {1'b0, b_sh[WIDTH-1:1]};
                br_nxt   = br_bit;
                cnt_nxt  = cnt + CNT_W'(1);
                if (cnt == LAST_BIT) begin
                    cnt_nxt      = '0;
                    state_nxt    = IDLE;
                    busy_nxt     = 1'b0;
                    done_nxt     = 1'b1;
                    diff_nxt     = {d_bit, a_sh[WIDTH-1:1]};
                    borrow_nxt   = br_bit;
                    overflow_nxt = (a_msb != b_msb) && (d_bit != a_msb);
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            a_sh     <= a_sh_nxt;
            b_sh     <= b_sh_nxt;
            cnt      <= cnt_nxt;
            br       <= br_nxt;
            a_msb    <= a_msb_nxt;
            b_msb    <= b_msb_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            diff     <= diff_nxt;
            borrow   <= borrow_nxt;
            overflow <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Expected results and completion cycles are queued at start and checked on done.
module tb_serial_subtractor;

    typedef struct {
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start4, start8;
    logic [3:0] a4, b4, diff4;
    logic [7:0] a8, b8, diff8;
    logic       busy4, done4, borrow4, overflow4;
    logic       busy8, done8, borrow8, overflow8;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt4 = 0, done_cnt8 = 0;
    int   exp_dones4 = 0, exp_dones8 = 0;
    int   snap;
    logic prev_done4 = 1'b0, prev_done8 = 1'b0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(overflow4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(overflow8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model from signed/unsigned integer arithmetic
    function automatic exp_t model(input int unsigned w, input int unsigned av,
                                   input int unsigned bv, input int c);
        exp_t r;
        int unsigned half, full;
        int sa, sb, sd;
        half = 32'd1 << (w - 1);
        full = 32'd1 << w;
        sa = (av >= half) ? int'(av) - int'(full) : int'(av);
        sb = (bv >= half) ? int'(bv) - int'(full) : int'(bv);
        sd = sa - sb;
        r.diff   = (av - bv) & (full - 1);
        r.borrow = (av < bv);
        r.ovf    = (sd > int'(half) - 1) || (sd < -int'(half));
        r.cyc    = c;
        return r;
    endfunction

    // Called at a falling edge; the following rising edge samples start
    task automatic op4(input int unsigned av, input int unsigned bv, input bit accept);
        a4 = 4'(av);
        b4 = 4'(bv);
        start4 = 1'b1;
        if (accept) begin
            q4.push_back(model(4, av, bv, cyc + 1 + 4));
            exp_dones4++;
        end
    endtask

    task automatic op8(input int unsigned av, input int unsigned bv);
        a8 = 8'(av);
        b8 = 8'(bv);
        start8 = 1'b1;
        q8.push_back(model(8, av, bv, cyc + 1 + 8));
        exp_dones8++;
    endtask

    task automatic wait_done4();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done4 && n < 20);
        check("done4_wait", 32'(done4), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(q4.size() + q8.size()), 32'd0);
    endtask

    // Output monitors: compare each done pulse against the queued expectation
    always @(negedge clk) begin
        if (rst_n && done4) begin
            done_cnt4++;
            check("busy4_in_done", 32'(busy4), 32'd0);
            check("done4_pulse_width", 32'(prev_done4), 32'd0);
            if (q4.size() == 0) begin
                check("done4_unexpected", 32'(done4), 32'd0);
            end else begin
                e4 = q4.pop_front();
                check("diff4", 32'(diff4), e4.diff);
                check("borrow4", 32'(borrow4), 32'(e4.borrow));
                check("overflow4", 32'(overflow4), 32'(e4.ovf));
                check("latency4", 32'(cyc), 32'(e4.cyc));
            end
        end
        prev_done4 = done4;
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            done_cnt8++;
            check("busy8_in_done", 32'(busy8), 32'd0);
            if (q8.size() == 0) begin
                check("done8_unexpected", 32'(done8), 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("diff8", 32'(diff8), e8.diff);
                check("borrow8", 32'(borrow8), 32'(e8.borrow));
                check("overflow8", 32'(overflow8), 32'(e8.ovf));
                check("latency8", 32'(cyc), 32'(e8.cyc));
            end
        end
        prev_done8 = done8;
    end

    initial begin
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_diff4", 32'(diff4), 32'd0);
        check("rst_flags4", 32'({borrow4, overflow4}), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_diff8", 32'(diff8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single operation with borrow
        op4(12, 15, 1'b1);
        @(negedge clk);
        start4 = 1'b0;
        check("busy4_running", 32'(busy4), 32'd1);
        drain("drain_single");

        // Back-to-back: start held high, new operands on each done cycle
        @(negedge clk);
        op4(8, 3, 1'b1);
        wait_done4();
        op4(6, 7, 1'b1);
        wait_done4();
        op4(2, 14, 1'b1);
        wait_done4();
        op4(7, 8, 1'b1);
        @(negedge clk);
        start4 = 1'b0;
        drain("drain_b2b");

        // Start while busy is ignored
        @(negedge clk);
        snap = done_cnt4;
        op4(12, 2, 1'b1);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        op4(1, 1, 1'b0);
        @(negedge clk);
        start4 = 1'b0;
        drain("drain_ignored");
        repeat (8) @(negedge clk);
        check("ignored_one_done", 32'(done_cnt4 - snap), 32'd1);

        // Reset in the middle of a run aborts without a done pulse
        op4(9, 4, 1'b1);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy4", 32'(busy4), 32'd0);
        check("abort_diff4", 32'(diff4), 32'd0);
        check("abort_done4", 32'(done4), 32'd0);
        q4.delete();
        exp_dones4--;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt4), 32'(exp_dones4));
        op4(9, 4, 1'b1);
        @(negedge clk);
        start4 = 1'b0;
        drain("drain_after_abort");

        // Operands change after capture
        @(negedge clk);
        op4(5, 5, 1'b1);
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'd15;
        b4 = 4'd0;
        drain("drain_operand_change");

        // Eight-bit instance
        @(negedge clk);
        op8(8'h00, 8'h01);
        @(negedge clk);
        start8 = 1'b0;
        check("busy8_running", 32'(busy8), 32'd1);
        drain("drain_w8_a");
        @(negedge clk);
        op8(8'h80, 8'h01);
        @(negedge clk);
        start8 = 1'b0;
        drain("drain_w8_b");

        repeat (10) @(negedge clk);
        check("done_count4", 32'(done_cnt4), 32'(exp_dones4));
        check("done_count8", 32'(done_cnt8), 32'(exp_dones8));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
